cla_slice_seq: RTL and testbench

CLA_SLICE_SEQ -- requirements
Module: cla_slice_seq

---
 rtl/cla_slice_seq.sv | 185 ++++++++++++++++++
 tb/tb_cla_slice_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cla_slice_seq.sv
// cla_slice_seq
//   Slice-serial carry-lookahead result stage. A word of NSLICE 4-bit slices
//   arrives LSB slice first as per-bit propagate/generate pairs. Each slice's
//   carries are resolved by lookahead in one cycle. The slice's carry-out is
//   registered as the carry-in of the next slice. After the last slice, the
//   assembled word and its flags are presented with a valid/ready handshake.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   p, g [3:0]        per-bit propagate / generate of the current slice
//   cin               word carry-in (slice 0 only)
//   m                 mode, 1 = logic, 0 = arithmetic (latched on slice 0)
//   in_valid/in_ready slice input handshake
//   f [W-1:0]         result word, W = 4*NSLICE
//   cout, ovf, zero   carry out of MSB, signed overflow, f == 0
//   out_valid/out_ready result output handshake
//
// FSM states
//   state   | meaning
//   S_IDLE  | waiting for slice 0 of a new word
//   S_ACCUM | slices 1..NSLICE-1 being collected, k = next slice index
//   S_DONE  | result presented, waiting for out_ready
module cla_slice_seq #(
    parameter int NSLICE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            p,
    input  logic [3:0]            g,
    input  logic                  cin,
    input  logic                  m,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*NSLICE-1:0]   f,
    output logic                  cout,
    output logic                  ovf,
    output logic                  zero,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int W  = 4 * NSLICE;
    localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    f_q, f_d;
    logic            carry_q, carry_d;
    logic            mode_q, mode_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            zero_q, zero_d;

    logic            xfer;
    logic            last_slice;
    logic            word_done;
    logic            slice_cin;
    logic            slice_mode;
    logic [4:0]      c;
    logic [3:0]      h;
    logic [3:0]      sum;

    assign in_ready   = (state_q != S_DONE);
    assign out_valid  = (state_q == S_DONE);
    assign f          = f_q;
    assign cout       = cout_q;
    assign ovf        = ovf_q;
    assign zero       = zero_q;

    assign xfer       = in_valid && in_ready;
    assign last_slice = (k_q == KW'(NSLICE - 1));

    // Slice 0 takes cin/m straight from the port; later slices use the
    // registered carry and the mode latched with slice 0.
    always_comb begin
        slice_cin  = (state_q == S_IDLE) ? cin : carry_q;
        slice_mode = (state_q == S_IDLE) ? m : mode_q;
    end

    // Fully expanded lookahead: every carry is a two-level function of the
    // slice inputs and the slice carry-in. Logic mode forces all carries low.
    always_comb begin
        c[0] = slice_cin;
        c[1] = g[0] | (p[0] & slice_cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & slice_cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & slice_cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & slice_cin);
        if (slice_mode) begin
            c = 5'b0;
        end
        h   = p & ~g;
        sum = h ^ c[3:0];
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        f_d       = f_q;
        carry_d   = carry_q;
        mode_d    = mode_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        word_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    // Clear the word so slices not yet received read as 0.
                    f_d      = '0;
                    f_d[3:0] = sum;
                    mode_d   = m;
                    carry_d  = c[4];
                    if (NSLICE == 1) begin
                        word_done = 1'b1;
                    end else begin
                        k_d     = KW'(1);
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (xfer) begin
                    f_d[{k_q, 2'b00} +: 4] = sum;
                    carry_d = c[4];
                    if (last_slice) begin
                        word_done = 1'b1;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    k_d     = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                k_d     = '0;
            end
        endcase

        if (word_done) begin
            state_d = S_DONE;
            k_d     = '0;
            cout_d  = c[4];
            ovf_d   = c[3] ^ c[4];
            zero_d  = (f_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            f_q     <= '0;
            carry_q <= 1'b0;
            mode_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            f_q     <= f_d;
            carry_q <= carry_d;
            mode_q  <= mode_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: tb/tb_cla_slice_seq.sv
module tb_cla_slice_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  p, g;
    logic        cin, m;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] f;
    logic        cout, ovf, zero;
    logic        out_valid;
    logic        out_ready;

    cla_slice_seq #(.NSLICE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .p         (p),
        .g         (g),
        .cin       (cin),
        .m         (m),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .f         (f),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] f;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops one expected result each time the DUT presents a result.
    logic seen = 1'b0;
    always @(negedge clk) begin
        if (out_valid && !seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got f=%0h, expected no result", f);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_f",    32'(f),    32'(e.f));
                chk("mon_cout", 32'(cout), 32'(e.cout));
                chk("mon_ovf",  32'(ovf),  32'(e.ovf));
                chk("mon_zero", 32'(zero), 32'(e.zero));
            end
        end else if (!out_valid) begin
            seen = 1'b0;
        end
    end

    // Sends nsl slices of A/B; a full word pushes its expected result.
    // Non-zero slices get inverted cin/m to show they are ignored.
    task automatic send_word(input logic [15:0] a, input logic [15:0] b,
                             input logic ci, input logic mi,
                             input int nsl, input int gap, input int hold,
                             input logic [15:0] ef, input logic ec,
                             input logic ev, input logic ez);
        logic [15:0] pw, gw;
        pw = a | b;
        gw = a & b;
        if (nsl == 4) sb.push_back('{ef, ec, ev, ez});
        out_ready = (hold == 0);
        for (int k = 0; k < nsl; k++) begin
            chk("in_ready_accept", 32'(in_ready), 32'd1);
            p        = pw[4*k +: 4];
            g        = gw[4*k +: 4];
            cin      = (k == 0) ? ci : ~ci;
            m        = (k == 0) ? mi : ~mi;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            if (k < nsl - 1) begin
                chk("f_unreceived_zero", 32'(f >> (4*(k+1))), 32'd0);
                chk("no_early_valid", 32'(out_valid), 32'd0);
                for (int j = 0; j < gap; j++) begin
                    @(negedge clk);
                    chk("stall_no_valid", 32'(out_valid), 32'd0);
                    chk("stall_in_ready", 32'(in_ready), 32'd1);
                end
            end
        end
        if (nsl == 4) begin
            chk("latency_valid", 32'(out_valid), 32'd1);
            chk("done_in_ready", 32'(in_ready), 32'd0);
            for (int j = 0; j < hold; j++) begin
                @(negedge clk);
                chk("hold_valid",    32'(out_valid), 32'd1);
                chk("hold_f",        32'(f),         32'(ef));
                chk("hold_cout",     32'(cout),      32'(ec));
                chk("hold_zero",     32'(zero),      32'(ez));
                chk("hold_in_ready", 32'(in_ready),  32'd0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            chk("consumed_valid", 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        p         = '0;
        g         = '0;
        cin       = 1'b0;
        m         = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_f",         32'(f),         32'd0);
        chk("rst_cout",      32'(cout),      32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        chk("rst_zero",      32'(zero),      32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        //          A        B        cin   m     n  gap hold  f        cout  ovf   zero
        send_word(16'h1234, 16'h4321, 1'b0, 1'b0, 4, 0, 0, 16'h5555, 1'b0, 1'b0, 1'b0);
        send_word(16'hFFFF, 16'h0001, 1'b0, 1'b0, 4, 0, 0, 16'h0000, 1'b1, 1'b0, 1'b1);
        send_word(16'h7FFF, 16'h0001, 1'b0, 1'b0, 4, 0, 0, 16'h8000, 1'b0, 1'b1, 1'b0);
        send_word(16'hF0F0, 16'hFF00, 1'b0, 1'b1, 4, 0, 0, 16'h0FF0, 1'b0, 1'b0, 1'b0);
        send_word(16'h8000, 16'h8000, 1'b0, 1'b0, 4, 0, 0, 16'h0000, 1'b1, 1'b1, 1'b1);
        send_word(16'h0000, 16'h0000, 1'b1, 1'b0, 4, 0, 0, 16'h0001, 1'b0, 1'b0, 1'b0);
        send_word(16'hFFFF, 16'h0001, 1'b1, 1'b1, 4, 0, 0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        send_word(16'h1234, 16'h4321, 1'b0, 1'b0, 4, 3, 5, 16'h5555, 1'b0, 1'b0, 1'b0);

        // Reset after slice 1: the partial word must never be output.
        send_word(16'h1234, 16'h4321, 1'b0, 1'b0, 2, 0, 0, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_f",     32'(f),         32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("midrst_no_valid", 32'(out_valid), 32'd0);
        end
        send_word(16'h0001, 16'h0001, 1'b0, 1'b0, 4, 0, 0, 16'h0002, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
